// File: rtl/miriscv_hazard_ctrl.sv
// miriscv_hazard_ctrl
// Tracks register writers in flight in the E, M and MP stages. From these it
// picks the rs1/rs2 bypass source for the decode instruction and raises the
// decode stall on load-use and on MDU results that are not ready yet. It also
// flushes E on kill and keeps a saturating count of stall cycles.
module miriscv_hazard_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             d_valid_i,
   input  logic [4:0]       d_rs1_addr_i,
   input  logic [4:0]       d_rs2_addr_i,
   input  logic             d_rs1_used_i,
   input  logic             d_rs2_used_i,
   input  logic [4:0]       d_rd_addr_i,
   input  logic             d_rd_we_i,
   input  logic [1:0]       d_wb_src_i,
   input  logic             mem_stall_i,
   input  logic             kill_i,
   output logic [1:0]       rs1_bypass_o,
   output logic [1:0]       rs2_bypass_o,
   output logic             d_stall_o,
   output logic             issue_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   // Bypass select codes
   localparam logic [1:0] NO_BYPASS = 2'd0;
   localparam logic [1:0] BYPASS_E  = 2'd1;
   localparam logic [1:0] BYPASS_M  = 2'd2;
   localparam logic [1:0] BYPASS_MP = 2'd3;

   // Writeback source codes
   localparam logic [1:0] ALU_DATA  = 2'd0;
   localparam logic [1:0] MDU_DATA  = 2'd1;
   localparam logic [1:0] LSU_DATA  = 2'd2;
   localparam logic [1:0] CSR_DATA  = 2'd3;

   // Slot index 0 = E, 1 = M, 2 = MP (youngest first)
   logic [2:0] slot_vld_reg;
   logic [4:0] slot_rd_reg  [3];
   logic [1:0] slot_src_reg [3];

   logic [CNT_W-1:0] stall_cnt_reg;

   logic [4:0] rs_addr [2];
   logic [1:0] rs_used;
   logic [1:0] bypass_sel [2];
   logic [1:0] hazard;

   assign rs_addr[0] = d_rs1_addr_i;
   assign rs_addr[1] = d_rs2_addr_i;
   assign rs_used[0] = d_rs1_used_i;
   assign rs_used[1] = d_rs2_used_i;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         logic [2:0] hit;
         logic [1:0] sel;
         logic       hz;

         // Compare this source against every slot; x0 never matches
         always_comb begin
            hit = '0;
            for (int s = 0; s < 3; s++) begin
               hit[s] = rs_used[gi] && (rs_addr[gi] != 5'd0) &&
                        slot_vld_reg[s] && (slot_rd_reg[s] == rs_addr[gi]);
            end
         end

         // Youngest match decides; MDU/LSU in E and LSU in M are not ready yet
         always_comb begin
            sel = NO_BYPASS;
            hz  = 1'b0;
            if (hit[0]) begin
               sel = BYPASS_E;
               hz  = (slot_src_reg[0] == MDU_DATA) || (slot_src_reg[0] == LSU_DATA);
            end else if (hit[1]) begin
               sel = BYPASS_M;
               hz  = (slot_src_reg[1] == LSU_DATA);
            end else if (hit[2]) begin
               sel = BYPASS_MP;
            end
         end

         assign bypass_sel[gi] = sel;
         assign hazard[gi]     = hz;
      end
   endgenerate

   assign rs1_bypass_o = bypass_sel[0];
   assign rs2_bypass_o = bypass_sel[1];
   assign d_stall_o    = mem_stall_i | (d_valid_i & (|hazard));
   assign issue_o      = d_valid_i & ~d_stall_o & ~kill_i & ~rst_i;
   assign stall_cnt_o  = stall_cnt_reg;

   // Advance the tracking slots; everything freezes under memory back-pressure except kill of E
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_vld_reg <= '0;
         for (int s = 0; s < 3; s++) begin
            slot_rd_reg[s]  <= 5'd0;
            slot_src_reg[s] <= ALU_DATA;
         end
      end else if (!mem_stall_i) begin
         slot_vld_reg[2] <= slot_vld_reg[1];
         slot_rd_reg[2]  <= slot_rd_reg[1];
         slot_src_reg[2] <= slot_src_reg[1];
         // A killed E entry must not reach M
         slot_vld_reg[1] <= slot_vld_reg[0] & ~kill_i;
         slot_rd_reg[1]  <= slot_rd_reg[0];
         slot_src_reg[1] <= slot_src_reg[0];
         slot_vld_reg[0] <= issue_o & d_rd_we_i & (d_rd_addr_i != 5'd0);
         slot_rd_reg[0]  <= d_rd_addr_i;
         slot_src_reg[0] <= d_wb_src_i;
      end else if (kill_i) begin
         slot_vld_reg[0] <= 1'b0;
      end
   end

   // Count cycles where a valid decode instruction is held, saturating at all-ones
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_reg <= '0;
      end else if (d_valid_i && d_stall_o && (stall_cnt_reg != {CNT_W{1'b1}})) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

endmodule

// File: tb/tb_miriscv_hazard_ctrl.sv
// Directed testbench for miriscv_hazard_ctrl (2-bit stall counter instance).
module tb_miriscv_hazard_ctrl;

   localparam int unsigned CNT_W = 2;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             d_valid_i;
   logic [4:0]       d_rs1_addr_i;
   logic [4:0]       d_rs2_addr_i;
   logic             d_rs1_used_i;
   logic             d_rs2_used_i;
   logic [4:0]       d_rd_addr_i;
   logic             d_rd_we_i;
   logic [1:0]       d_wb_src_i;
   logic             mem_stall_i;
   logic             kill_i;
   logic [1:0]       rs1_bypass_o;
   logic [1:0]       rs2_bypass_o;
   logic             d_stall_o;
   logic             issue_o;
   logic [CNT_W-1:0] stall_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   miriscv_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .d_valid_i    (d_valid_i),
      .d_rs1_addr_i (d_rs1_addr_i),
      .d_rs2_addr_i (d_rs2_addr_i),
      .d_rs1_used_i (d_rs1_used_i),
      .d_rs2_used_i (d_rs2_used_i),
      .d_rd_addr_i  (d_rd_addr_i),
      .d_rd_we_i    (d_rd_we_i),
      .d_wb_src_i   (d_wb_src_i),
      .mem_stall_i  (mem_stall_i),
      .kill_i       (kill_i),
      .rs1_bypass_o (rs1_bypass_o),
      .rs2_bypass_o (rs2_bypass_o),
      .d_stall_o    (d_stall_o),
      .issue_o      (issue_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Put an instruction in decode and let outputs settle
   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic [1:0] src);
      d_valid_i    = v;
      d_rs1_addr_i = rs1;
      d_rs1_used_i = u1;
      d_rs2_addr_i = rs2;
      d_rs2_used_i = u2;
      d_rd_addr_i  = rd;
      d_rd_we_i    = we;
      d_wb_src_i   = src;
      #1;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_i = 1'b1; mem_stall_i = 1'b0; kill_i = 1'b0;
      // Reset: a valid instruction must not issue while rst_i is high
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 2'd0);
      check("rst_issue", issue_o, 0);
      step(); step();
      rst_i = 1'b0;
      drive(1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 2'd0);
      check("rst_rs1_byp", rs1_bypass_o, 0);
      check("rst_rs2_byp", rs2_bypass_o, 0);
      check("rst_stall", d_stall_o, 0);
      check("rst_cnt", stall_cnt_o, 0);
      mem_stall_i = 1'b1; #1;
      check("rst_stall_mem", d_stall_o, 1);
      mem_stall_i = 1'b0; #1;

      // ALU back-to-back: E, then M, then MP bypass
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd0);
      check("alu_prod_issue", issue_o, 1);
      step();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'd0);
      check("alu_byp_e", rs1_bypass_o, 1);
      check("alu_stall", d_stall_o, 0);
      check("alu_issue", issue_o, 1);
      step();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
      check("alu_byp_m", rs1_bypass_o, 2);
      step();
      check("alu_byp_mp", rs1_bypass_o, 3);
      step();
      check("alu_drained", rs1_bypass_o, 0);
      idle(3);

      // Load-use: two stall cycles, then MP bypass on rs2
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2);
      step();
      drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 2'd0);
      check("lu_stall1", d_stall_o, 1);
      check("lu_issue1", issue_o, 0);
      step();
      check("lu_stall2", d_stall_o, 1);
      step();
      check("lu_stall3", d_stall_o, 0);
      check("lu_byp_mp", rs2_bypass_o, 3);
      check("lu_issue", issue_o, 1);
      check("lu_cnt", stall_cnt_o, 2);
      step();
      idle(3);

      // x0 writer is never tracked
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd2);
      step();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 2'd0);
      check("x0_byp", rs1_bypass_o, 0);
      check("x0_stall", d_stall_o, 0);
      step();
      idle(3);

      // Priority: x9 in both E and M -> E wins
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd0);
      step();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd3);
      step();
      drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 2'd0);
      check("prio_rs1", rs1_bypass_o, 1);
      check("prio_rs2", rs2_bypass_o, 1);
      check("prio_stall", d_stall_o, 0);
      step();
      idle(3);

      // mem_stall freeze: selects hold BYPASS_E for 3 cycles; counter saturates at 3
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd0);
      step();
      mem_stall_i = 1'b1;
      drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
      for (int i = 0; i < 3; i++) begin
         check("ms_stall", d_stall_o, 1);
         check("ms_byp", rs1_bypass_o, 1);
         check("ms_issue", issue_o, 0);
         step();
      end
      mem_stall_i = 1'b0; #1;
      check("ms_rel_stall", d_stall_o, 0);
      check("ms_rel_byp", rs1_bypass_o, 1);
      check("ms_rel_issue", issue_o, 1);
      check("ms_cnt_sat", stall_cnt_o, 3);
      step();
      idle(3);

      // MDU-use: one stall cycle, then M bypass
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 2'd1);
      step();
      drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
      check("mdu_stall1", d_stall_o, 1);
      step();
      check("mdu_stall2", d_stall_o, 0);
      check("mdu_byp_m", rs1_bypass_o, 2);
      step();
      idle(3);

      // Kill with hazard: no issue, then E is empty and consumer issues
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'd2);
      step();
      kill_i = 1'b1;
      drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
      check("kill_issue", issue_o, 0);
      check("kill_stall", d_stall_o, 1);
      step();
      kill_i = 1'b0; #1;
      check("kill_byp", rs1_bypass_o, 0);
      check("kill_stall_after", d_stall_o, 0);
      check("kill_issue_after", issue_o, 1);
      step();
      idle(3);

      // Saturation from zero, then reset mid-hazard
      rst_i = 1'b1; step(); rst_i = 1'b0; #1;
      check("sat_cnt0", stall_cnt_o, 0);
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd2);
      step();
      mem_stall_i = 1'b1;
      drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
      step(); step();
      check("sat_cnt2", stall_cnt_o, 2);
      step(); step(); step();
      check("sat_cnt5", stall_cnt_o, 3);
      check("sat_hazard", d_stall_o, 1);
      mem_stall_i = 1'b0;
      rst_i = 1'b1; #1;
      check("rst_mid_issue", issue_o, 0);
      step();
      rst_i = 1'b0; #1;
      check("rst_mid_cnt", stall_cnt_o, 0);
      check("rst_mid_byp", rs1_bypass_o, 0);
      check("rst_mid_stall", d_stall_o, 0);
      check("rst_mid_issue2", issue_o, 1);
      step();
      idle(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/miriscv_hazard_ctrl.md
# miriscv_hazard_ctrl

Pipeline hazard controller for the miriscv core. It tracks in-flight register writers in the E, M and MP stages and selects the operand bypass source for the decode-stage instruction. It also generates the decode stall for load-use and not-yet-ready results, handles flush of the E stage, and counts stall cycles. It sits beside the decode stage and drives the rs1/rs2 bypass muxes with the `miriscv_decode_pkg` codes `NO_BYPASS`/`BYPASS_E`/`BYPASS_M`/`BYPASS_MP` (0/1/2/3). Writeback source types use `ALU_DATA`/`MDU_DATA`/`LSU_DATA`/`CSR_DATA` (0/1/2/3).

## Interface

Parameters:
- `CNT_W`, default 32: width of the stall performance counter.

Ports:
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `d_valid_i`  in  1  valid instruction in decode.
- `d_rs1_addr_i`, `d_rs2_addr_i`  in  5  source register addresses.
- `d_rs1_used_i`, `d_rs2_used_i`  in  1  the instruction reads the corresponding source.
- `d_rd_addr_i`  in  5  destination register.
- `d_rd_we_i`  in  1  the instruction writes rd.
- `d_wb_src_i`  in  2  writeback source type (`WB_SRC_W` codes).
- `mem_stall_i`  in  1  LSU or memory back-pressure; freezes E/M/MP.
- `kill_i`  in  1  flush from branch/exception resolution in E.
- `rs1_bypass_o`, `rs2_bypass_o`  out  2  bypass select for each source.
- `d_stall_o`  out  1  hold the fetch/decode registers.
- `issue_o`  out  1  the decode instruction enters E this cycle.
- `stall_cnt_o`  out  `CNT_W`  saturating count of stall cycles.

## Operation

- **Tracking slots.** Three slots, E, M and MP, each holding {`vld`, `rd[4:0]`, `src[1:0]`}.
- **Slot load rule.** A slot is loaded with `vld=1` only when `d_rd_we_i=1` and `d_rd_addr_i!=0`. Writers to x0 are never tracked.
- **Match rule for source X.** Source X matches a slot when `d_rsX_used_i=1`, the address is nonzero, `slot.vld=1` and `slot.rd` equals the address. The youngest match wins, with priority E > M > MP.
- **Bypass and hazard selection**, per source, taking the highest-priority match:
  - E match with `src` in {`ALU_DATA`, `CSR_DATA`} → `BYPASS_E`.
  - E match with `src` in {`MDU_DATA`, `LSU_DATA`} → hazard.
  - M match with `src != LSU_DATA` → `BYPASS_M`.
  - M match with `src == LSU_DATA` → hazard.
  - MP match, any `src` → `BYPASS_MP`.
  - No match → `NO_BYPASS`.
- **Bypass output gating.** Bypass selects are driven regardless of `d_valid_i`. On a hazard the select still shows the matched stage's code, but it is don't-care while stalled.
- **Stall and issue.**
  - `d_stall_o = mem_stall_i | (d_valid_i & (hazard_rs1 | hazard_rs2))`.
  - `issue_o = d_valid_i & ~d_stall_o & ~kill_i & ~rst_i`.
- **Slot advance when `mem_stall_i=0`:**
  - MP ← M.
  - M ← E.
  - E ← decode instruction if `issue_o`, otherwise a bubble (`vld=0`).
- **Slot advance when `mem_stall_i=1`:** all slots hold.
- **Kill.** `kill_i=1` clears `E.vld` at the next edge, even when `mem_stall_i=1`. M and MP follow the rules above, so without `mem_stall_i` the killed E entry does not advance into M. No issue occurs in a kill cycle.
- **Stall counter.** `stall_cnt_o` increments by 1 every cycle in which `d_valid_i & d_stall_o`. It saturates at all-ones and never wraps.
- **Reset.** Reset clears all slot `vld` bits and clears `stall_cnt_o`.

## Timing

- Bypass selects, `d_stall_o` and `issue_o` are combinational from the registered slots and current inputs. There is no added latency.
- Slot state changes one cycle after `issue_o`. An instruction issued at cycle t sits in E at t+1, M at t+2 and MP at t+3, absent `mem_stall_i`.
- Each `mem_stall_i` cycle shifts those stage-occupancy times by one cycle.
- Resulting stall lengths for a dependent instruction immediately following its producer:
  - Load-use: 2 stall cycles.
  - MDU-use: 1 stall cycle.
  - ALU-use: 0 stall cycles, bypassed from E.
- Reset values, with `rst_i=1` at the edge:
  - All slots invalid and `stall_cnt_o=0`.
  - After that edge, `rs1_bypass_o`/`rs2_bypass_o` = `NO_BYPASS` and `d_stall_o = mem_stall_i`.
  - `issue_o=0` while `rst_i=1`.
- Reset asserted mid-stall discards all slot contents. No hazard persists after release.
- Simultaneous `kill_i` and hazard: `issue_o=0`. `d_stall_o` still reflects the hazard. The counter counts the cycle if `d_valid_i`.

## Test plan

- **ALU back-to-back.** Issue `add x5` (`ALU_DATA`), then next cycle `sub` reading rs1=x5 → `rs1_bypass_o=1`, `d_stall_o=0`, `issue_o=1`. One cycle later the same read gives `rs1_bypass_o=2`; one cycle after that it gives 3.
- **Load-use.** Issue `lw x7` (`LSU_DATA`), then consumer with rs2=x7 → `d_stall_o=1` for exactly 2 cycles, then `rs2_bypass_o=3` and `issue_o=1`. `stall_cnt_o` increases by 2.
- **x0 and priority.** Producer writes x0, consumer reads x0 → `NO_BYPASS`, no stall. For priority: producers write x9 in E and in M simultaneously → `BYPASS_E`.
- **mem_stall freeze.** Issue an ALU producer for x3, then assert `mem_stall_i` for 3 cycles with a consumer of x3 in decode → `d_stall_o=1` for 3 cycles and selects stay `BYPASS_E`. After release → issue with `BYPASS_E`.
- **Kill.** `lw x4` in E with a consumer of x4 in decode, assert `kill_i` → `issue_o=0`. Next cycle the E slot is invalid, and the consumer sees `NO_BYPASS` and issues.
- **Reset and saturation.** With `CNT_W=2`, hold a hazard for 5 cycles → counter reads 3. Then assert `rst_i` mid-hazard → counter 0, slots empty, `d_stall_o=0` after release.
